// File: rtl/matrix_bank.sv
// Matrix bank: stores up to SLOTS matrices for every (m,n) shape up to MAX_DIM x MAX_DIM.
// A write FSM fills a round-robin slot from an element stream, with zero-pad and abort.
// A read FSM streams a stored matrix out under valid/ready.
module matrix_bank #(
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned SLOTS   = 2,
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned DIM_W   = 3,
    parameter int unsigned SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_start,
    input  logic [DIM_W-1:0]             wr_m,
    input  logic [DIM_W-1:0]             wr_n,
    input  logic [ELEM_W-1:0]            wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic                         wr_finish,
    input  logic                         wr_abort,
    output logic                         wr_done,
    output logic                         wr_err,
    output logic [SLOT_W-1:0]            wr_slot,
    input  logic                         rd_start,
    input  logic [DIM_W-1:0]             rd_m,
    input  logic [DIM_W-1:0]             rd_n,
    input  logic [SLOT_W-1:0]            rd_slot,
    output logic [ELEM_W-1:0]            rd_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic                         rd_last,
    output logic                         rd_err,
    output logic                         rd_busy,
    input  logic [DIM_W-1:0]             query_m,
    input  logic [DIM_W-1:0]             query_n,
    output logic [SLOTS-1:0]             query_mask,
    output logic [$clog2(SLOTS+1)-1:0]   query_count
);

    localparam int unsigned ELEMS   = MAX_DIM * MAX_DIM;
    localparam int unsigned COMBOS  = MAX_DIM * MAX_DIM;
    localparam int unsigned NMAT    = COMBOS * SLOTS;
    localparam int unsigned DEPTH   = NMAT * ELEMS;
    localparam int unsigned COMBO_W = (COMBOS > 1) ? $clog2(COMBOS) : 1;
    localparam int unsigned MAT_W   = (NMAT > 1) ? $clog2(NMAT) : 1;
    localparam int unsigned IDX_W   = $clog2(ELEMS + 1);
    localparam int unsigned ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_PAD} w_state_e;
    typedef enum logic [0:0] {R_IDLE, R_STREAM} r_state_e;

    function automatic logic dims_ok(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n);
        return (m != '0) && (n != '0) && (32'(m) <= MAX_DIM) && (32'(n) <= MAX_DIM);
    endfunction

    // Only meaningful for valid dims; callers mux in zero otherwise to keep indices in range.
    function automatic logic [COMBO_W-1:0] combo_of(input logic [DIM_W-1:0] m,
                                                    input logic [DIM_W-1:0] n);
        return COMBO_W'((32'(m) - 1) * MAX_DIM + (32'(n) - 1));
    endfunction

    function automatic logic [MAT_W-1:0] mat_of(input logic [COMBO_W-1:0] c,
                                                input logic [SLOT_W-1:0] s);
        return MAT_W'(32'(c) * SLOTS + 32'(s));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [MAT_W-1:0] mat,
                                                  input logic [IDX_W-1:0] idx);
        return ADDR_W'(32'(mat) * ELEMS + 32'(idx));
    endfunction

    function automatic logic [IDX_W-1:0] size_of(input logic [DIM_W-1:0] m,
                                                 input logic [DIM_W-1:0] n);
        return IDX_W'(32'(m) * 32'(n));
    endfunction

    // Element storage; contents deliberately survive reset.
    logic [ELEM_W-1:0] mem [DEPTH];

    logic [NMAT-1:0]   valid_q, valid_d;
    logic [SLOT_W-1:0] rr_q [COMBOS];
    logic [SLOT_W-1:0] rr_d [COMBOS];

    w_state_e          w_state_q, w_state_d;
    logic [MAT_W-1:0]  wr_mat_q, wr_mat_d;
    logic [IDX_W-1:0]  wr_total_q, wr_total_d;
    logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic              wr_done_q, wr_done_d;
    logic              wr_err_q, wr_err_d;

    r_state_e          r_state_q, r_state_d;
    logic [MAT_W-1:0]  rd_mat_q, rd_mat_d;
    logic [IDX_W-1:0]  rd_total_q, rd_total_d;
    logic [IDX_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ELEM_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              rd_err_q, rd_err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr, rd_raddr;
    logic [ELEM_W-1:0] mem_wdata;
    logic              wr_commit;

    // Start-request decode for both ports.
    logic               wr_ok, rd_ok, rd_accept, wr_conflict, wr_cnt_last;
    logic [COMBO_W-1:0] wr_combo, rd_combo;
    logic [SLOT_W-1:0]  wr_target;
    logic [MAT_W-1:0]   wr_new_mat, rd_new_mat;

    assign wr_ok       = dims_ok(wr_m, wr_n);
    assign wr_combo    = wr_ok ? combo_of(wr_m, wr_n) : '0;
    assign wr_target   = rr_q[wr_combo];
    assign wr_new_mat  = mat_of(wr_combo, wr_target);
    assign rd_combo    = dims_ok(rd_m, rd_n) ? combo_of(rd_m, rd_n) : '0;
    assign rd_new_mat  = mat_of(rd_combo, rd_slot);
    assign rd_ok       = dims_ok(rd_m, rd_n) && (32'(rd_slot) < SLOTS) && valid_q[rd_new_mat];
    assign rd_accept   = (r_state_q == R_IDLE) && rd_start && rd_ok;
    // A write may not reuse a slot that is streaming now or starts streaming this cycle.
    assign wr_conflict = ((r_state_q == R_STREAM) && (rd_mat_q == wr_new_mat)) ||
                         (rd_accept && (rd_new_mat == wr_new_mat));
    assign wr_cnt_last = ((wr_cnt_q + IDX_W'(1)) == wr_total_q);

    // Write FSM next state, memory write port, valid flags and round-robin pointers.
    always_comb begin
        w_state_d  = w_state_q;
        wr_mat_d   = wr_mat_q;
        wr_total_d = wr_total_q;
        wr_cnt_d   = wr_cnt_q;
        wr_slot_d  = wr_slot_q;
        wr_done_d  = 1'b0;
        wr_err_d   = 1'b0;
        valid_d    = valid_q;
        rr_d       = rr_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_of(wr_mat_q, wr_cnt_q);
        mem_wdata  = wr_data;
        wr_commit  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (wr_start) begin
                    if (!wr_ok || wr_conflict) begin
                        wr_err_d = 1'b1;
                    end else begin
                        valid_d[wr_new_mat] = 1'b0;
                        rr_d[wr_combo] = (32'(wr_target) == SLOTS - 1) ? '0 : wr_target + 1'b1;
                        wr_slot_d  = wr_target;
                        wr_mat_d   = wr_new_mat;
                        wr_total_d = size_of(wr_m, wr_n);
                        wr_cnt_d   = '0;
                        w_state_d  = W_FILL;
                    end
                end
            end
            W_FILL: begin
                if (wr_abort) begin
                    w_state_d = W_IDLE;
                end else if (wr_valid) begin
                    mem_we = 1'b1;
                    if (wr_cnt_last) begin
                        wr_commit = 1'b1;
                    end else begin
                        wr_cnt_d = wr_cnt_q + IDX_W'(1);
                        if (wr_finish) w_state_d = W_PAD;
                    end
                end else if (wr_finish) begin
                    w_state_d = W_PAD;
                end
            end
            W_PAD: begin
                if (wr_abort) begin
                    w_state_d = W_IDLE;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = '0;
                    if (wr_cnt_last) wr_commit = 1'b1;
                    else wr_cnt_d = wr_cnt_q + IDX_W'(1);
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        if (wr_commit) begin
            valid_d[wr_mat_q] = 1'b1;
            wr_done_d         = 1'b1;
            w_state_d         = W_IDLE;
        end
    end

    // Read FSM next state; rd_data is registered straight from the array.
    always_comb begin
        r_state_d  = r_state_q;
        rd_mat_d   = rd_mat_q;
        rd_total_d = rd_total_q;
        rd_cnt_d   = rd_cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_err_d   = 1'b0;
        rd_raddr   = addr_of(rd_new_mat, '0);
        unique case (r_state_q)
            R_IDLE: begin
                if (rd_start) begin
                    if (rd_ok) begin
                        r_state_d  = R_STREAM;
                        rd_mat_d   = rd_new_mat;
                        rd_total_d = size_of(rd_m, rd_n);
                        rd_cnt_d   = '0;
                        rd_data_d  = mem[rd_raddr];
                        rd_valid_d = 1'b1;
                        rd_last_d  = (size_of(rd_m, rd_n) == IDX_W'(1));
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            R_STREAM: begin
                rd_raddr = addr_of(rd_mat_q, rd_cnt_q + IDX_W'(1));
                if (rd_ready) begin
                    if (rd_last_q) begin
                        r_state_d  = R_IDLE;
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                    end else begin
                        rd_cnt_d  = rd_cnt_q + IDX_W'(1);
                        rd_data_d = mem[rd_raddr];
                        rd_last_d = ((rd_cnt_q + IDX_W'(2)) == rd_total_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State registers for both FSMs, flags and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            wr_mat_q   <= '0;
            wr_total_q <= '0;
            wr_cnt_q   <= '0;
            wr_slot_q  <= '0;
            wr_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            r_state_q  <= R_IDLE;
            rd_mat_q   <= '0;
            rd_total_q <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            valid_q    <= '0;
            for (int unsigned i = 0; i < COMBOS; i++) rr_q[i] <= '0;
        end else begin
            w_state_q  <= w_state_d;
            wr_mat_q   <= wr_mat_d;
            wr_total_q <= wr_total_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_slot_q  <= wr_slot_d;
            wr_done_q  <= wr_done_d;
            wr_err_q   <= wr_err_d;
            r_state_q  <= r_state_d;
            rd_mat_q   <= rd_mat_d;
            rd_total_q <= rd_total_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_err_q   <= rd_err_d;
            valid_q    <= valid_d;
            rr_q       <= rr_d;
        end
    end

    // Storage write port, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Combinational slot-occupancy query.
    always_comb begin
        query_mask  = '0;
        query_count = '0;
        if (dims_ok(query_m, query_n)) begin
            query_mask = valid_q[32'(combo_of(query_m, query_n)) * SLOTS +: SLOTS];
        end
        for (int unsigned i = 0; i < SLOTS; i++) begin
            query_count = query_count + CNT_W'(query_mask[i]);
        end
    end

    assign wr_ready = (w_state_q == W_FILL);
    assign wr_done  = wr_done_q;
    assign wr_err   = wr_err_q;
    assign wr_slot  = wr_slot_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_err   = rd_err_q;
    assign rd_busy  = (r_state_q == R_STREAM);

endmodule

// File: doc/matrix_bank.md
MATRIX_BANK -- requirements
Module: matrix_bank

Interface
REQ-001 Parameter MAX_DIM, default 5, maximum rows/columns per matrix (1..7).
REQ-002 Parameter SLOTS, default 2, storage slots per (m,n) dimension combo (>=1).
REQ-003 Parameter ELEM_W, default 8, element width in bits.
REQ-004 Parameter DIM_W, default 3, width of row/column/dimension ports.
REQ-005 Parameter SLOT_W, default $clog2(SLOTS) (min 1), width of the slot index.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 wr_start  in  1  begin writing an m x n matrix.
REQ-009 wr_m, wr_n  in  DIM_W  dimensions of the matrix to write.
REQ-010 wr_data / wr_valid  in  ELEM_W / 1  element stream; wr_ready  out  1  element accepted when wr_valid && wr_ready.
REQ-011 wr_finish  in  1  input ended early: zero-pad the remainder.
REQ-012 wr_abort  in  1  cancel the write in progress.
REQ-013 wr_done, wr_err  out  1  one-cycle completion / rejection pulses; wr_slot  out  SLOT_W  slot used by the last accepted wr_start.
REQ-014 rd_start  in  1  begin streaming a stored matrix; rd_m, rd_n  in  DIM_W; rd_slot  in  SLOT_W.
REQ-015 rd_data  out  ELEM_W; rd_valid  out  1; rd_ready  in  1; rd_last  out  1  final element; rd_err  out  1  one-cycle pulse; rd_busy  out  1.
REQ-016 query_m, query_n  in  DIM_W; query_mask  out  SLOTS  per-slot valid flags; query_count  out  $clog2(SLOTS+1)  number of set bits; both combinational.

Function
REQ-017 Storage: MAX_DIM*MAX_DIM*SLOTS matrices of MAX_DIM*MAX_DIM elements; combo = (m-1)*MAX_DIM + (n-1); row-major element order.
REQ-018 Dimensions are valid only when 1 <= m,n <= MAX_DIM; invalid query dimensions yield query_mask = 0.
REQ-019 Write FSM states: W_IDLE, W_FILL, W_PAD; rd FSM states: R_IDLE, R_STREAM.
REQ-020 W_IDLE + wr_start + valid dims: target = per-combo round-robin pointer; clear target valid flag; advance pointer mod SLOTS; latch dims; enter W_FILL next cycle.
REQ-021 wr_start with invalid dims, or targeting the slot currently streamed by the read FSM: wr_err pulse next cycle, no state change; wr_start outside W_IDLE ignored.
REQ-022 W_FILL: wr_ready = 1; each accepted element written at the next row-major position.
REQ-023 When element m*n is accepted: set target valid flag, wr_done pulse the following cycle, return to W_IDLE.
REQ-024 wr_finish in W_FILL with fewer than m*n elements: enter W_PAD, wr_ready = 0, write one zero per cycle until m*n, then commit as REQ-023; wr_finish with zero elements accepted still pads the whole matrix.
REQ-025 wr_abort in W_FILL or W_PAD: return to W_IDLE, target valid flag stays 0, no wr_done; wr_abort has priority over a same-cycle element or wr_finish.
REQ-026 R_IDLE + rd_start: when dims are valid, rd_slot < SLOTS, and the slot valid flag is set, enter R_STREAM; otherwise rd_err pulse next cycle.
REQ-027 R_STREAM: first rd_valid one cycle after rd_start; rd_data/rd_last held stable while rd_valid && !rd_ready; advance on handshake; rd_last = 1 with element m*n; after final handshake return to R_IDLE with rd_valid = 0.
REQ-028 rd_busy = 1 in R_STREAM; rd_start ignored while busy.
REQ-029 Read and write FSMs run concurrently on different slots; a read and a write in the same cycle do not stall each other.
REQ-030 A commit in the same cycle as a query is visible on query_mask the following cycle.

Reset
REQ-031 rst clears all valid flags and round-robin pointers, returns both FSMs to idle, and drives wr_ready, wr_done, wr_err, wr_slot, rd_valid, rd_last, rd_err, rd_busy, and rd_data to 0.
REQ-032 Matrix contents are not reset; rst mid-write leaves the target slot invalid.

Verification
REQ-033 Write 2x3 {1..6} -> wr_done after sixth handshake; query(2,3) mask=01, count=1; read slot0 streams 1,2,3,4,5,6 with rd_last on 6.
REQ-034 Three 1x1 writes 7,8,9 (SLOTS=2) -> slots hold 9,8; wr_slot sequence 0,1,0; mask=11.
REQ-035 Write 3x3, send 4 elements then wr_finish -> 5 padded zeros, wr_done; read yields 4 values then 0,0,0,0,0.
REQ-036 Abort 2x2 after 2 elements -> no wr_done, mask bit 0; read that slot -> rd_err pulse.
REQ-037 Read 2x2 with rd_ready toggled 1,0,0,1,... -> rd_data stable during stalls, exactly 4 handshakes, rd_last once.
REQ-038 wr_start with m=6 or n=0 -> wr_err pulse, wr_ready stays 0; rst during W_FILL -> all outputs 0, mask 0.
